load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// The master holds a request until the slave answers with dmem_ready.
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_ready,
    output dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: passes non-memory results straight to writeback one cycle
// later, and runs loads/stores as a single held request on the dmem bus.
// Optional feature macro LSU_MISALIGN_TRAP_EN: refuse misaligned accesses and
// pulse misalign_err instead; when undefined misalign_err is tied low.
module load_store_unit (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ALU_OUT,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd_in,
  input  logic              flush,
  load_store_unit_if.master dmem,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              lsu_stall,
  output logic              misalign_err
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic [0:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  sz_q, sz_d;
  logic        sext_q, sext_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  logic        accept;
  logic        mem_op;
  logic [1:0]  req_sz;
  logic [1:0]  req_off;
  logic        misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [15:0] ld_shift;
  logic [31:0] ld_data;

  assign accept  = (state_q == StIdle) && ex_valid && !flush;
  assign mem_op  = ex_is_load || ex_is_store;
  assign req_off = ALU_OUT[1:0];

  // Decode access size, alignment, lane enables and replicated store data.
  always_comb begin
    req_sz    = SzWord;
    req_be    = 4'b1111;
    req_wdata = store_data;
    if (ex_is_store) begin
      // Unknown store encodings fall back to a full word.
      case (ex_funct3)
        3'b000:  req_sz = SzByte;
        3'b001:  req_sz = SzHalf;
        default: req_sz = SzWord;
      endcase
    end else begin
      // Bit 2 only selects zero-extension for loads.
      case (ex_funct3[1:0])
        2'b00:   req_sz = SzByte;
        2'b01:   req_sz = SzHalf;
        default: req_sz = SzWord;
      endcase
    end
    misaligned = ((req_sz == SzHalf) && req_off[0]) ||
                 ((req_sz == SzWord) && (req_off != 2'b00));
    case (req_sz)
      SzByte: begin
        req_be    = 4'b0001 << req_off;
        req_wdata = {4{store_data[7:0]}};
      end
      SzHalf: begin
        req_be    = 4'b0011 << req_off;
        req_wdata = {2{store_data[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = store_data;
      end
    endcase
  end

  // Extract and extend the addressed lane; lanes past the word read as zero.
  always_comb begin
    ld_shift = 16'(dmem.dmem_rdata >> {off_q, 3'b000});
    case (sz_q)
      SzByte:  ld_data = {{24{sext_q & ld_shift[7]}}, ld_shift[7:0]};
      SzHalf:  ld_data = {{16{sext_q & ld_shift[15]}}, ld_shift};
      default: ld_data = dmem.dmem_rdata;
    endcase
  end

  // Next-state: accept in IDLE, hold the request in BUSY until ready.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    off_d      = off_q;
    sz_d       = sz_q;
    sext_d     = sext_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (!mem_op) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ALU_OUT;
            wb_rd_d    = rd_in;
          end else if (!(TrapEn && misaligned)) begin
            state_d = StBusy;
            we_d    = ex_is_store;
            addr_d  = {ALU_OUT[31:2], 2'b00};
            be_d    = req_be;
            wdata_d = req_wdata;
            off_d   = req_off;
            sz_d    = req_sz;
            sext_d  = !ex_funct3[2];
            rd_d    = rd_in;
          end
        end
      end
      default: begin
        if (dmem.dmem_ready) begin
          state_d = StIdle;
          if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ld_data;
            wb_rd_d    = rd_q;
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      off_q      <= '0;
      sz_q       <= SzByte;
      sext_q     <= 1'b0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      off_q      <= off_d;
      sz_q       <= sz_d;
      sext_q     <= sext_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // A refused misaligned op raises the flag for exactly one cycle.
  always_comb begin
    misalign_d = accept && mem_op && misaligned;
  end

  // Trap flag register.
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign dmem.dmem_req   = (state_q == StBusy);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign lsu_stall       = (state_q == StBusy);
  assign wb_valid        = wb_valid_q;
  assign wb_data         = wb_data_q;
  assign wb_rd           = wb_rd_q;

endmodule
